// File: rtl/trig_time_fifo_reader_pkg.sv
// trig_time_fifo_reader_pkg: FSM states, output word layout and widths shared by the reader and its pending counter
package trig_time_fifo_reader_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPTURE, ST_EMIT} state_t;
  localparam int PEND_W = 4;
  localparam int CNT_W = 16;
  localparam int TAG_LSB = 28;
  localparam int TIMEOUT_BIT = 27;
  localparam int OVF_BIT = 26;
  localparam int CNT_LSB = 8;
  localparam logic [3:0] WORD_TAG_DEF = 4'hD;
  function automatic logic [31:0] pack_word(
    input logic [3:0] tag,
    input logic timeout,
    input logic ovf,
    input logic [CNT_W-1:0] cnt,
    input logic [7:0] t
  );
    logic [31:0] w;
    w = '0;
    w[TAG_LSB +: 4] = tag;
    w[TIMEOUT_BIT] = timeout;
    w[OVF_BIT] = ovf;
    w[CNT_LSB +: CNT_W] = cnt;
    w[7:0] = t;
    return w;
  endfunction
endpackage

// File: rtl/trig_time_fifo_reader_req_counter.sv
// trig_req_counter: saturating pending-request counter with sticky lost-request flag
//   clk, rst_n (async, active low), clear (sync)
//   inc   : new request      dec : request taken into service
//   count : pending requests lost : request dropped while saturated (sticky)
module trig_req_counter
  import trig_time_fifo_reader_pkg::*;
#(
  parameter int PEND_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              lost
);
  localparam logic [PEND_W-1:0] MAX = PEND_W'(PEND_MAX);
  logic drop;
  // a simultaneous dec makes room, so only a lone inc at MAX is dropped
  assign drop = inc && !dec && (count == MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      lost <= 1'b0;
    end else if (clear) begin
      count <= '0;
      lost <= 1'b0;
    end else begin
      count <= (inc && !dec && !drop) ? count + 1'b1 : (dec && !inc) ? count - 1'b1 : count;
      lost <= lost | drop;
    end
endmodule

// File: rtl/trig_time_fifo_reader.sv
// trig_time_fifo_reader: pops one trigger-time byte per event request and emits a tagged 32-bit word
//   clk, rst_n (async, active low), clear (sync, same effect as reset)
//   evt_req                      : one pulse per event needing a trigger time
//   fifo_q/fifo_empty/fifo_full  : FIFO read side (normal mode, data one cycle after fifo_rd)
//   fifo_rd                      : one-cycle pop request
//   data_out/data_valid/data_ready : word to event builder, valid/ready handshake
//   busy : FSM active or requests pending   req_lost : sticky request drop
module trig_time_fifo_reader
  import trig_time_fifo_reader_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         PEND_MAX       = 15,
  parameter logic [3:0] WORD_TAG       = WORD_TAG_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        evt_req,
  input  logic [7:0]  fifo_q,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        fifo_rd,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        req_lost
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] evt_cnt;
  logic ovf;
  logic [PEND_W-1:0] pending;
  logic take;
  logic accept;
  assign take = (state == ST_IDLE) && (pending != '0);
  assign accept = data_valid && data_ready;
  // combinational so a pop can never coincide with an empty FIFO
  assign fifo_rd = (state == ST_WAIT) && !fifo_empty;
  assign busy = (state != ST_IDLE) || (pending != '0);
  trig_req_counter #(.PEND_MAX(PEND_MAX)) u_req (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (evt_req),
    .dec   (take),
    .count (pending),
    .lost  (req_lost)
  );
  // data_out doubles as the time register; it is frozen while in EMIT.
  // The overflow bit also folds in a FIFO_FULL seen on the packing cycle itself.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
      evt_cnt <= '0;
      ovf <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      timer <= '0;
      evt_cnt <= '0;
      ovf <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
    end else begin
      ovf <= ovf | fifo_full;
      case (state)
        ST_IDLE:
          if (take) begin
            state <= ST_WAIT;
            timer <= '0;
          end
        ST_WAIT:
          if (!fifo_empty) state <= ST_CAPTURE;
          else if (timer == TO_LAST) begin
            state <= ST_EMIT;
            data_valid <= 1'b1;
            data_out <= pack_word(WORD_TAG, 1'b1, ovf | fifo_full, evt_cnt, 8'h00);
          end else timer <= timer + 1'b1;
        ST_CAPTURE: begin
          state <= ST_EMIT;
          data_valid <= 1'b1;
          data_out <= pack_word(WORD_TAG, 1'b0, ovf | fifo_full, evt_cnt, fifo_q);
        end
        ST_EMIT:
          if (accept) begin
            state <= ST_IDLE;
            data_valid <= 1'b0;
            data_out <= '0;
            evt_cnt <= evt_cnt + 1'b1;
            ovf <= fifo_full;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_trig_time_fifo_reader.sv
// tb_trig_time_fifo_reader: directed vectors plus stall, saturation, reset and clear sequences
module tb_trig_time_fifo_reader;
  typedef struct {
    logic [7:0]  t;
    logic        use_fifo;
    logic        pre_full;
    int          lat;
    logic [31:0] word;
  } vec_t;
  logic clk = 0, rst_n = 0, clear = 0, evt_req = 0, fifo_full = 0, data_ready = 0;
  logic [7:0] fifo_q = 0;
  logic fifo_empty, fifo_rd, data_valid, busy, req_lost;
  logic [31:0] data_out;
  logic [7:0] mem [0:63];
  logic [7:0] wr_ptr = 0, rd_ptr = 0;
  int rd_cnt = 0, bad_rd = 0, nchk = 0, nerr = 0;
  int lat, rd0;
  vec_t tbl [6];
  logic [31:0] exp2 [3];
  assign fifo_empty = (wr_ptr == rd_ptr);
  always #5 clk = ~clk;
  trig_time_fifo_reader #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .evt_req    (evt_req),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_rd    (fifo_rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .req_lost   (req_lost)
  );
  always @(posedge clk)
    if (fifo_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) bad_rd <= bad_rd + 1;
      else begin
        fifo_q <= mem[rd_ptr[5:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask
  task automatic wait_valid(output int l);
    l = 0;
    do begin
      @(negedge clk);
      evt_req = 0;
      l++;
    end while (!data_valid && l < 200);
    chk("wait_valid", {31'b0, data_valid}, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'h5A, 1'b1, 1'b0, 4,  32'hD000005A};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 18, 32'hD8000100};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 4,  32'hD40002A5};
    tbl[3] = '{8'h3C, 1'b1, 1'b0, 4,  32'hD000033C};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 4,  32'hD40004FF};
    tbl[5] = '{8'h00, 1'b0, 1'b1, 18, 32'hDC000500};
    exp2[0] = 32'hD0000611;
    exp2[1] = 32'hD0000722;
    exp2[2] = 32'hD0000833;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, data_valid}, 0);
    chk("rst_out", data_out, 0);
    chk("rst_rd", {31'b0, fifo_rd}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_lost", {31'b0, req_lost}, 0);
    rst_n = 1;
    data_ready = 1;
    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].pre_full) begin
        fifo_full = 1;
        @(negedge clk);
        fifo_full = 0;
      end
      if (tbl[i].use_fifo) push(tbl[i].t);
      rd0 = rd_cnt;
      evt_req = 1;
      wait_valid(lat);
      chk($sformatf("v%0d_word", i), data_out, tbl[i].word);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_rd", i), rd_cnt - rd0, {31'b0, tbl[i].use_fifo});
      @(negedge clk);
      chk($sformatf("v%0d_done", i), {31'b0, data_valid}, 0);
    end
    data_ready = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      evt_req = 1;
      @(negedge clk);
    end
    evt_req = 0;
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_word", data_out, exp2[0]);
      chk("stall_valid", {31'b0, data_valid}, 1);
    end
    data_ready = 1;
    chk("b2b_word0", data_out, exp2[0]);
    for (int k = 1; k < 3; k++) begin
      wait_valid(lat);
      chk($sformatf("b2b_word%0d", k), data_out, exp2[k]);
    end
    @(negedge clk);
    chk("b2b_rd", rd_cnt - rd0, 3);
    data_ready = 0;
    rd0 = rd_cnt;
    for (int i = 0; i < 17; i++) begin
      evt_req = 1;
      @(negedge clk);
      if (i == 15) chk("lost_before", {31'b0, req_lost}, 0);
    end
    evt_req = 0;
    chk("lost_sat", {31'b0, req_lost}, 1);
    wait_valid(lat);
    data_ready = 1;
    chk("sat_word0", data_out, 32'hD8000900);
    for (int k = 1; k < 16; k++) begin
      wait_valid(lat);
      chk($sformatf("sat_word%0d", k), data_out, 32'hD8000000 | 32'((9 + k) << 8));
    end
    @(negedge clk);
    chk("sat_idle", {31'b0, busy}, 0);
    repeat (40) @(negedge clk);
    chk("sat_no_extra", {31'b0, data_valid}, 0);
    chk("sat_no_rd", rd_cnt - rd0, 0);
    chk("lost_sticky", {31'b0, req_lost}, 1);
    data_ready = 0;
    push(8'h77);
    evt_req = 1;
    wait_valid(lat);
    rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, data_valid}, 0);
    chk("arst_out", data_out, 0);
    chk("arst_lost", {31'b0, req_lost}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1;
    data_ready = 1;
    push(8'h88);
    evt_req = 1;
    wait_valid(lat);
    chk("arst_word", data_out, 32'hD0000088);
    chk("arst_lat", lat, 4);
    @(negedge clk);
    data_ready = 0;
    push(8'h99);
    evt_req = 1;
    wait_valid(lat);
    chk("pre_clr_word", data_out, 32'hD0000199);
    fifo_full = 1;
    @(negedge clk);
    fifo_full = 0;
    clear = 1;
    #1;
    chk("clr_sync", {31'b0, data_valid}, 1);
    @(negedge clk);
    chk("clr_valid", {31'b0, data_valid}, 0);
    chk("clr_out", data_out, 0);
    clear = 0;
    data_ready = 1;
    push(8'h44);
    evt_req = 1;
    wait_valid(lat);
    chk("clr_word", data_out, 32'hD0000044);
    @(negedge clk);
    chk("no_empty_rd", bad_rd, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
